// File: rtl/vls_nch_pkg.sv
// Purpose    : shared types for the N-channel vector load/store controller.
// Latency    : n/a (types and helpers only).
// Backpressure: n/a.
package vls_nch_pkg;

  // Scratchpad command opcode. 2'b11 is deliberately left unnamed: it is the
  // illegal encoding, and the controller answers it with an error response.
  typedef enum logic [1:0] {
    VLS_NOP   = 2'b00,
    VLS_LOAD  = 2'b01,
    VLS_STORE = 2'b10
  } vls_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } vls_state_t;

  function automatic logic vls_op_legal(input logic [1:0] op);
    return (op != 2'b11);
  endfunction

endpackage

// File: rtl/vls_nch_channel.sv
// Purpose    : one scratchpad channel: command register, address adder, done flag, load capture.
// Latency    : address registered at accept; sp_valid drops the cycle after an accepted sp_dhit.
// Backpressure: request held (all sp_* fields stable) until sp_dhit while issue is high.
// Ports: load/clear/issue/is_load from the top FSM; *_in command fields; dhit/rdata from
//        the scratchpad; sp_* request fields, vd, done, fin (channel finished or finishing
//        this cycle) and captured data back to the top.
module vls_channel
  import vls_nch_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IMM_W  = 8,
  parameter int unsigned DIM_W  = 6,
  parameter int unsigned VREG_W = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load,
  input  logic              clear,
  input  logic              issue,
  input  logic              is_load,
  input  logic              en_in,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [IMM_W-1:0]  imm,
  input  logic [VREG_W-1:0] vd_in,
  input  logic              row_col_in,
  input  logic              id_in,
  input  logic [DIM_W-1:0]  num_rows_in,
  input  logic [DIM_W-1:0]  num_cols_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              dhit,
  input  logic [DATA_W-1:0] rdata,
  output logic              sp_valid,
  output logic [ADDR_W-1:0] sp_addr,
  output logic              sp_row_col,
  output logic              sp_id,
  output logic [DIM_W-1:0]  sp_num_rows,
  output logic [DIM_W-1:0]  sp_num_cols,
  output logic [DATA_W-1:0] sp_wdata,
  output logic [VREG_W-1:0] vd,
  output logic              done,
  output logic              fin,
  output logic [DATA_W-1:0] data
);

  logic              en;
  logic              hit;
  logic [ADDR_W-1:0] imm_sx;

  // Size cast of a signed operand sign-extends; the sum wraps modulo 2^ADDR_W.
  assign imm_sx   = ADDR_W'($signed(imm));
  assign sp_valid = issue & en & ~done;
  // Hits outside an active request (disabled, already done, not issuing) are dropped.
  assign hit      = dhit & sp_valid;
  // A disabled channel counts as finished so the top can AND all channels together.
  assign fin      = ~en | done | hit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      en          <= 1'b0;
      sp_addr     <= '0;
      sp_row_col  <= 1'b0;
      sp_id       <= 1'b0;
      sp_num_rows <= '0;
      sp_num_cols <= '0;
      sp_wdata    <= '0;
      vd          <= '0;
      done        <= 1'b0;
      data        <= '0;
    end else begin
      if (load) begin
        en          <= en_in;
        sp_addr     <= rs1 + imm_sx;
        sp_row_col  <= row_col_in;
        sp_id       <= id_in;
        sp_num_rows <= num_rows_in;
        sp_num_cols <= num_cols_in;
        sp_wdata    <= wdata_in;
        vd          <= vd_in;
      end
      if (clear) begin
        done <= 1'b0;
        data <= '0;
      end else if (hit) begin
        done <= 1'b1;
        if (is_load) data <= rdata;
      end
    end
  end

endmodule

// File: rtl/vls_nch.sv
// Purpose    : N-channel vector load/store controller between vector issue and scratchpad.
// Latency    : accept at edge 0, sp_valid in cycle 1, resp_valid the cycle after the last hit (min 3 cycles/cmd).
// Backpressure: one command in flight; req_ready only in IDLE; response held until resp_ready.
// Ports: req_* command from issue (per-channel fields packed channel 0 in the LSBs),
//        sp_* per-channel scratchpad request/completion, resp_* single combined response.
module vls_nch
  import vls_nch_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned IMM_W       = 8,
  parameter int unsigned DIM_W       = 6,
  parameter int unsigned VREG_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 64  // must be >= 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [NUM_CH-1:0]        req_ch_en,
  input  logic [NUM_CH*ADDR_W-1:0] req_rs1,
  input  logic [NUM_CH*IMM_W-1:0]  req_imm,
  input  logic [NUM_CH*VREG_W-1:0] req_vd,
  input  logic [NUM_CH-1:0]        req_row_col,
  input  logic [NUM_CH-1:0]        req_id,
  input  logic [NUM_CH*DIM_W-1:0]  req_num_rows,
  input  logic [NUM_CH*DIM_W-1:0]  req_num_cols,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        sp_valid,
  output logic [1:0]               sp_op,
  output logic [NUM_CH*ADDR_W-1:0] sp_addr,
  output logic [NUM_CH-1:0]        sp_row_col,
  output logic [NUM_CH-1:0]        sp_id,
  output logic [NUM_CH*DIM_W-1:0]  sp_num_rows,
  output logic [NUM_CH*DIM_W-1:0]  sp_num_cols,
  output logic [NUM_CH*DATA_W-1:0] sp_wdata,
  input  logic [NUM_CH-1:0]        sp_dhit,
  input  logic [NUM_CH*DATA_W-1:0] sp_rdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [1:0]               resp_op,
  output logic [NUM_CH*VREG_W-1:0] resp_vd,
  output logic [NUM_CH*DATA_W-1:0] resp_data,
  output logic [NUM_CH-1:0]        resp_done,
  output logic                     resp_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  vls_state_t         state;
  logic [1:0]         op_q;
  logic               err_q;
  logic               req_ready_q;
  logic               resp_valid_q;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_CH-1:0]  ch_fin;
  logic               ch_load;
  logic               ch_clear;
  logic               in_issue;
  logic               is_load;

  assign ch_load  = (state == IDLE) & req_valid;
  assign ch_clear = (state == RESP) & resp_ready;
  assign in_issue = (state == ISSUE);
  assign is_load  = (op_q == VLS_LOAD);

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = err_q;
  assign resp_op    = op_q;
  assign sp_op      = op_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    vls_channel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .IMM_W  (IMM_W),
      .DIM_W  (DIM_W),
      .VREG_W (VREG_W)
    ) u_ch (
      .CLK         (CLK),
      .nRST        (nRST),
      .load        (ch_load),
      .clear       (ch_clear),
      .issue       (in_issue),
      .is_load     (is_load),
      .en_in       (req_ch_en[c]),
      .rs1         (req_rs1[c*ADDR_W +: ADDR_W]),
      .imm         (req_imm[c*IMM_W +: IMM_W]),
      .vd_in       (req_vd[c*VREG_W +: VREG_W]),
      .row_col_in  (req_row_col[c]),
      .id_in       (req_id[c]),
      .num_rows_in (req_num_rows[c*DIM_W +: DIM_W]),
      .num_cols_in (req_num_cols[c*DIM_W +: DIM_W]),
      .wdata_in    (req_wdata[c*DATA_W +: DATA_W]),
      .dhit        (sp_dhit[c]),
      .rdata       (sp_rdata[c*DATA_W +: DATA_W]),
      .sp_valid    (sp_valid[c]),
      .sp_addr     (sp_addr[c*ADDR_W +: ADDR_W]),
      .sp_row_col  (sp_row_col[c]),
      .sp_id       (sp_id[c]),
      .sp_num_rows (sp_num_rows[c*DIM_W +: DIM_W]),
      .sp_num_cols (sp_num_cols[c*DIM_W +: DIM_W]),
      .sp_wdata    (sp_wdata[c*DATA_W +: DATA_W]),
      .vd          (resp_vd[c*VREG_W +: VREG_W]),
      .done        (resp_done[c]),
      .fin         (ch_fin[c]),
      .data        (resp_data[c*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      op_q         <= 2'b00;
      err_q        <= 1'b0;
      cnt          <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            req_ready_q <= 1'b0;
            if (!vls_op_legal(req_op)) begin
              err_q        <= 1'b1;
              resp_valid_q <= 1'b1;
              state        <= RESP;
            end else if (|req_ch_en) begin
              state <= ISSUE;
            end else begin
              // Empty mask: nothing to issue, answer immediately without error.
              resp_valid_q <= 1'b1;
              state        <= RESP;
            end
          end
        end
        ISSUE: begin
          // Completion wins over the watchdog when the last hit lands on the final cycle.
          if (&ch_fin) begin
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            err_q        <= 1'b1;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            err_q        <= 1'b0;
            cnt          <= '0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vls_nch.sv
// Purpose    : self-checking bench for vls_nch (NUM_CH=2, TIMEOUT_CYC=8).
// Latency    : checks cycle-exact timing relative to the accept edge.
// Backpressure: exercises resp_ready held low during a timeout response.
module tb_vls_nch;

  localparam int NUM_CH      = 2;
  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int IMM_W       = 8;
  localparam int DIM_W       = 6;
  localparam int VREG_W      = 4;
  localparam int TIMEOUT_CYC = 8;

  typedef struct {
    logic [1:0]               op;
    logic                     err;
    logic [NUM_CH-1:0]        done;
    logic [NUM_CH*DATA_W-1:0] data;
    logic [NUM_CH*VREG_W-1:0] vd;
  } exp_t;

  logic                     CLK = 1'b0;
  logic                     nRST = 1'b0;
  logic                     req_valid = 1'b0;
  logic                     req_ready;
  logic [1:0]               req_op = 2'b00;
  logic [NUM_CH-1:0]        req_ch_en = '0;
  logic [NUM_CH*ADDR_W-1:0] req_rs1 = '0;
  logic [NUM_CH*IMM_W-1:0]  req_imm = '0;
  logic [NUM_CH*VREG_W-1:0] req_vd = '0;
  logic [NUM_CH-1:0]        req_row_col = '0;
  logic [NUM_CH-1:0]        req_id = '0;
  logic [NUM_CH*DIM_W-1:0]  req_num_rows = '0;
  logic [NUM_CH*DIM_W-1:0]  req_num_cols = '0;
  logic [NUM_CH*DATA_W-1:0] req_wdata = '0;
  logic [NUM_CH-1:0]        sp_valid;
  logic [1:0]               sp_op;
  logic [NUM_CH*ADDR_W-1:0] sp_addr;
  logic [NUM_CH-1:0]        sp_row_col;
  logic [NUM_CH-1:0]        sp_id;
  logic [NUM_CH*DIM_W-1:0]  sp_num_rows;
  logic [NUM_CH*DIM_W-1:0]  sp_num_cols;
  logic [NUM_CH*DATA_W-1:0] sp_wdata;
  logic [NUM_CH-1:0]        sp_dhit = '0;
  logic [NUM_CH*DATA_W-1:0] sp_rdata = '0;
  logic                     resp_valid;
  logic                     resp_ready = 1'b1;
  logic [1:0]               resp_op;
  logic [NUM_CH*VREG_W-1:0] resp_vd;
  logic [NUM_CH*DATA_W-1:0] resp_data;
  logic [NUM_CH-1:0]        resp_done;
  logic                     resp_err;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  vls_nch #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_W(IMM_W),
    .DIM_W(DIM_W), .VREG_W(VREG_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_ch_en(req_ch_en),
    .req_rs1(req_rs1), .req_imm(req_imm), .req_vd(req_vd), .req_row_col(req_row_col),
    .req_id(req_id), .req_num_rows(req_num_rows), .req_num_cols(req_num_cols),
    .req_wdata(req_wdata),
    .sp_valid(sp_valid), .sp_op(sp_op), .sp_addr(sp_addr), .sp_row_col(sp_row_col),
    .sp_id(sp_id), .sp_num_rows(sp_num_rows), .sp_num_cols(sp_num_cols),
    .sp_wdata(sp_wdata), .sp_dhit(sp_dhit), .sp_rdata(sp_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
    .resp_vd(resp_vd), .resp_data(resp_data), .resp_done(resp_done), .resp_err(resp_err)
  );

  // Scoreboard: compare the response contents whenever a response handshake is seen.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (nRST && resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_unexpected_resp: got resp op=%b err=%b, want no response", resp_op, resp_err);
        end else begin
          e = sb.pop_front();
          n_chk++; if (resp_op !== e.op) begin n_fail++; $display("FAIL sb_op: got %b want %b", resp_op, e.op); end
          n_chk++; if (resp_err !== e.err) begin n_fail++; $display("FAIL sb_err: got %b want %b", resp_err, e.err); end
          n_chk++; if (resp_done !== e.done) begin n_fail++; $display("FAIL sb_done: got %b want %b", resp_done, e.done); end
          n_chk++; if (resp_data !== e.data) begin n_fail++; $display("FAIL sb_data: got %h want %h", resp_data, e.data); end
          n_chk++; if (resp_vd !== e.vd) begin n_fail++; $display("FAIL sb_vd: got %h want %h", resp_vd, e.vd); end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Drives one command at the current negedge; returns at the negedge of cycle 1.
  task automatic send_cmd(input logic [1:0] op, input logic [1:0] en,
                          input logic [31:0] rs1, input logic [15:0] imm,
                          input logic [7:0] vd, input logic [31:0] wd);
    req_valid = 1'b1; req_op = op; req_ch_en = en; req_rs1 = rs1;
    req_imm = imm; req_vd = vd; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_op = 2'b00; req_ch_en = '0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    tick(); tick();
    n_chk++; if (sp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_sp_valid: got %b want 00", sp_valid); end
    n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_chk++; if (sp_addr !== 32'h0) begin n_fail++; $display("FAIL reset_sp_addr: got %h want 0", sp_addr); end
    n_chk++; if ({resp_err, resp_done, resp_data} !== '0) begin n_fail++; $display("FAIL reset_resp: got %b/%b/%h want 0", resp_err, resp_done, resp_data); end
    nRST = 1'b1;
    tick();
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_load();
    req_row_col = 2'b10; req_id = 2'b01; req_num_rows = {6'd9, 6'd3}; req_num_cols = {6'd17, 6'd33};
    sb.push_back('{op: 2'b01, err: 1'b0, done: 2'b11, data: 32'h5555_AAAA, vd: 8'h73});
    send_cmd(2'b01, 2'b11, 32'h0200_0100, 16'hFE05, 8'h73, 32'h0);
    n_chk++; if (sp_valid !== 2'b11) begin n_fail++; $display("FAIL load_sp_valid_c1: got %b want 11", sp_valid); end
    n_chk++; if (sp_addr !== 32'h01FE_0105) begin n_fail++; $display("FAIL load_sp_addr: got %h want 01fe0105", sp_addr); end
    n_chk++; if (sp_op !== 2'b01) begin n_fail++; $display("FAIL load_sp_op: got %b want 01", sp_op); end
    n_chk++; if ({sp_row_col, sp_id, sp_num_rows, sp_num_cols} !== {2'b10, 2'b01, 6'd9, 6'd3, 6'd17, 6'd33})
      begin n_fail++; $display("FAIL load_sp_fields: got %b %b %h %h", sp_row_col, sp_id, sp_num_rows, sp_num_cols); end
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL load_req_ready_busy: got %b want 0", req_ready); end
    sp_dhit = 2'b11; sp_rdata = 32'h5555_AAAA;
    tick();
    sp_dhit = 2'b00; sp_rdata = '0;
    n_chk++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL load_resp_valid_c2: got %b want 1", resp_valid); end
    n_chk++; if (sp_valid !== 2'b00) begin n_fail++; $display("FAIL load_sp_valid_c2: got %b want 00", sp_valid); end
    tick();
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL load_req_ready_c3: got %b want 1", req_ready); end
    n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL load_resp_valid_c3: got %b want 0", resp_valid); end
  endtask

  task automatic test_store_split();
    sb.push_back('{op: 2'b10, err: 1'b0, done: 2'b11, data: 32'h0, vd: 8'h21});
    send_cmd(2'b10, 2'b11, 32'h0010_0020, 16'h0000, 8'h21, 32'hBEEF_CAFE);
    n_chk++; if (sp_wdata !== 32'hBEEF_CAFE) begin n_fail++; $display("FAIL store_wdata_c1: got %h want beefcafe", sp_wdata); end
    sp_dhit = 2'b01;
    tick();
    sp_dhit = 2'b00;
    for (int cyc = 2; cyc <= 4; cyc++) begin
      n_chk++; if (sp_valid !== 2'b10) begin n_fail++; $display("FAIL store_sp_valid_c%0d: got %b want 10", cyc, sp_valid); end
      n_chk++; if (sp_wdata !== 32'hBEEF_CAFE) begin n_fail++; $display("FAIL store_wdata_c%0d: got %h want beefcafe", cyc, sp_wdata); end
      if (cyc == 4) sp_dhit = 2'b10;
      tick();
    end
    sp_dhit = 2'b00;
    n_chk++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL store_resp_valid_c5: got %b want 1", resp_valid); end
    n_chk++; if (sp_valid !== 2'b00) begin n_fail++; $display("FAIL store_sp_valid_c5: got %b want 00", sp_valid); end
    tick();
  endtask

  task automatic test_mask();
    sb.push_back('{op: 2'b01, err: 1'b0, done: 2'b10, data: 32'h1234_0000, vd: 8'h5A});
    send_cmd(2'b01, 2'b10, 32'h0300_0400, 16'h0101, 8'h5A, 32'h0);
    n_chk++; if (sp_valid !== 2'b10) begin n_fail++; $display("FAIL mask_sp_valid_c1: got %b want 10", sp_valid); end
    sp_dhit = 2'b01; sp_rdata = 32'h9999_7777;
    tick();
    n_chk++; if (sp_valid !== 2'b10) begin n_fail++; $display("FAIL mask_sp_valid_c2: got %b want 10", sp_valid); end
    sp_dhit = 2'b10; sp_rdata = 32'h1234_8888;
    tick();
    sp_dhit = 2'b00; sp_rdata = '0;
    n_chk++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL mask_resp_valid_c3: got %b want 1", resp_valid); end
    tick();
  endtask

  task automatic test_illegal_and_empty();
    sb.push_back('{op: 2'b11, err: 1'b1, done: 2'b00, data: 32'h0, vd: 8'h11});
    send_cmd(2'b11, 2'b11, 32'h0, 16'h0, 8'h11, 32'h0);
    n_chk++; if (sp_valid !== 2'b00) begin n_fail++; $display("FAIL illegal_sp_valid: got %b want 00", sp_valid); end
    n_chk++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_resp_valid_c1: got %b want 1", resp_valid); end
    tick();
    sb.push_back('{op: 2'b01, err: 1'b0, done: 2'b00, data: 32'h0, vd: 8'h22});
    send_cmd(2'b01, 2'b00, 32'h0, 16'h0, 8'h22, 32'h0);
    n_chk++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL empty_resp_valid_c1: got %b want 1", resp_valid); end
    tick();
  endtask

  task automatic test_timeout();
    logic [45:0] snap;
    resp_ready = 1'b0;
    sb.push_back('{op: 2'b01, err: 1'b1, done: 2'b00, data: 32'h0, vd: 8'h44});
    send_cmd(2'b01, 2'b11, 32'h0, 16'h0, 8'h44, 32'h0);
    for (int cyc = 1; cyc <= TIMEOUT_CYC; cyc++) begin
      n_chk++; if (sp_valid !== 2'b11 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_issue_c%0d: got sp_valid=%b resp_valid=%b want 11/0", cyc, sp_valid, resp_valid); end
      tick();
    end
    n_chk++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin n_fail++; $display("FAIL timeout_resp_c9: got valid=%b err=%b want 1/1", resp_valid, resp_err); end
    n_chk++; if (sp_valid !== 2'b00) begin n_fail++; $display("FAIL timeout_sp_valid_c9: got %b want 00", sp_valid); end
    snap = {resp_valid, resp_op, resp_vd, resp_data, resp_done, resp_err};
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if ({resp_valid, resp_op, resp_vd, resp_data, resp_done, resp_err} !== snap)
        begin n_fail++; $display("FAIL timeout_hold_%0d: got %h want %h", k, {resp_valid, resp_op, resp_vd, resp_data, resp_done, resp_err}, snap); end
    end
    resp_ready = 1'b1;
    tick();
    n_chk++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got req_ready=%b resp_valid=%b want 1/0", req_ready, resp_valid); end
  endtask

  task automatic test_wrap_reset();
    send_cmd(2'b01, 2'b11, 32'h0000_FFFF, 16'h8002, 8'h66, 32'h0);
    n_chk++; if (sp_addr !== 32'hFF80_0001) begin n_fail++; $display("FAIL wrap_sp_addr: got %h want ff800001", sp_addr); end
    tick();
    #1 nRST = 1'b0;
    #1;
    n_chk++; if (sp_valid !== 2'b00 || resp_valid !== 1'b0 || sp_addr !== 32'h0)
      begin n_fail++; $display("FAIL midreset_outputs: got sp_valid=%b resp_valid=%b sp_addr=%h want 0", sp_valid, resp_valid, sp_addr); end
    #1 nRST = 1'b1;
    @(negedge CLK);
    sb.push_back('{op: 2'b01, err: 1'b0, done: 2'b01, data: 32'h0000_0F0F, vd: 8'h09});
    send_cmd(2'b01, 2'b01, 32'h0000_0010, 16'h0001, 8'h09, 32'h0);
    n_chk++; if (sp_valid !== 2'b01 || sp_addr[15:0] !== 16'h0011) begin n_fail++; $display("FAIL postreset_issue: got sp_valid=%b addr=%h want 01/0011", sp_valid, sp_addr[15:0]); end
    sp_dhit = 2'b01; sp_rdata = 32'h0000_0F0F;
    tick();
    sp_dhit = 2'b00; sp_rdata = '0;
    n_chk++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL postreset_resp_valid: got %b want 1", resp_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_split();
    test_mask();
    test_illegal_and_empty();
    test_timeout();
    test_wrap_reset();
    tick();
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
